squid_error_corrector: RTL and testbench

//  Downstream consumer of the Forney stage. Takes the received 8-symbol GF(16) codeword,
//  the Forney magnitudes and the one-hot Chien error location. It classifies the word as
//  NE/CE/DUE, XOR-corrects the located symbol, and returns the result through a 2-stage

---
 rtl/squid_error_corrector.sv | 166 ++++++++++++++++
 tb/tb_squid_error_corrector.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/squid_error_corrector.sv
// squid_error_corrector
//   Final stage of the GF(16) symbol decoder. Accepts the received 8-symbol
//   codeword together with the Forney magnitudes and the one-hot Chien error
//   location. It classifies the word as NE / CE / DUE, XOR-corrects the
//   located symbol, and returns the result through a 2-stage valid/ready
//   pipeline. Saturating CE / DUE counters track delivered beats.
//
// Ports
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready, in_codeword, in_magnitude[NUM_SYM], in_err_loc,
//   in_synd_zero   input beat
//   out_valid/out_ready, out_codeword, out_status, out_err_sym
//                  corrected output beat (status 00 NE, 01 CE, 10 DUE)
//   ce_count, due_count  saturating counts of delivered CE / DUE beats
//   cnt_clear      synchronous clear of both counters (wins over increment)
//
// Handshake: a beat moves across an interface in the cycle where valid and
//   ready are both high. A producer holds valid and its payload steady until
//   that happens; out_* therefore stay stable while out_valid && !out_ready.
//   in_ready depends combinationally on out_ready.

module squid_error_corrector #(
  parameter int CNT_W   = 16,
  parameter int NUM_SYM = 8,
  parameter int SYM_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_SYM*SYM_W-1:0]   in_codeword,
  input  logic [SYM_W-1:0]           in_magnitude [NUM_SYM-1:0],
  input  logic [NUM_SYM-1:0]         in_err_loc,
  input  logic                       in_synd_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_SYM*SYM_W-1:0]   out_codeword,
  output logic [1:0]                 out_status,
  output logic [$clog2(NUM_SYM)-1:0] out_err_sym,
  output logic [CNT_W-1:0]           ce_count,
  output logic [CNT_W-1:0]           due_count,
  input  logic                       cnt_clear
);

  localparam int CW_W  = NUM_SYM * SYM_W;
  localparam int IDX_W = $clog2(NUM_SYM);

  localparam logic [1:0] ST_NE  = 2'b00;
  localparam logic [1:0] ST_CE  = 2'b01;
  localparam logic [1:0] ST_DUE = 2'b10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1: raw capture of the input beat
  logic                 s1_valid;
  logic [CW_W-1:0]      s1_codeword;
  logic [SYM_W-1:0]     s1_magnitude [NUM_SYM-1:0];
  logic [NUM_SYM-1:0]   s1_err_loc;
  logic                 s1_synd_zero;

  // Classification / correction result of the word held in stage 1
  logic                 loc_onehot;
  logic [IDX_W-1:0]     loc_idx;
  logic [SYM_W-1:0]     loc_mag;
  logic [CW_W-1:0]      fix_mask;
  logic [CW_W-1:0]      res_codeword;
  logic [1:0]           res_status;
  logic [IDX_W-1:0]     res_err_sym;

  logic in_xfer;
  logic out_xfer;
  logic s2_load;

  // Stage 1 may accept when it is empty or when it empties into the output
  // stage this same cycle, which gives full throughput with no bubble.
  assign in_ready = !s1_valid || !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign s2_load  = s1_valid && (!out_valid || out_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_codeword  <= '0;
      s1_err_loc   <= '0;
      s1_synd_zero <= 1'b0;
      for (int i = 0; i < NUM_SYM; i++) s1_magnitude[i] <= '0;
    end else begin
      if (in_xfer) begin
        s1_valid     <= 1'b1;
        s1_codeword  <= in_codeword;
        s1_magnitude <= in_magnitude;
        s1_err_loc   <= in_err_loc;
        s1_synd_zero <= in_synd_zero;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_comb begin
    // A single located symbol: non-zero and a power of two.
    loc_onehot = (s1_err_loc != '0) &&
                 ((s1_err_loc & (s1_err_loc - NUM_SYM'(1))) == '0);
    loc_idx  = '0;
    fix_mask = '0;
    for (int i = 0; i < NUM_SYM; i++) begin
      if (s1_err_loc[i]) begin
        loc_idx = IDX_W'(i);
        fix_mask[i*SYM_W +: SYM_W] = s1_magnitude[i];
      end
    end
    loc_mag = s1_magnitude[loc_idx];

    res_codeword = s1_codeword;
    res_status   = ST_NE;
    res_err_sym  = '0;
    if (!s1_synd_zero) begin
      // A zero magnitude at the located root means Chien and Forney
      // disagree, so the word is not trusted as correctable.
      if (loc_onehot && (loc_mag != '0)) begin
        res_codeword = s1_codeword ^ fix_mask;
        res_status   = ST_CE;
        res_err_sym  = loc_idx;
      end else begin
        res_status = ST_DUE;
      end
    end
  end

  // Stage 2: output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_codeword <= '0;
      out_status   <= ST_NE;
      out_err_sym  <= '0;
    end else begin
      if (s2_load) begin
        out_valid    <= 1'b1;
        out_codeword <= res_codeword;
        out_status   <= res_status;
        out_err_sym  <= res_err_sym;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  // Event counters count delivered beats, not computed ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ce_count  <= '0;
      due_count <= '0;
    end else if (cnt_clear) begin
      ce_count  <= '0;
      due_count <= '0;
    end else if (out_xfer) begin
      if ((out_status == ST_CE) && (ce_count != CNT_MAX))
        ce_count <= ce_count + CNT_W'(1);
      if ((out_status == ST_DUE) && (due_count != CNT_MAX))
        due_count <= due_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_squid_error_corrector.sv
// tb_squid_error_corrector
//   Bench for squid_error_corrector. Two instances share all stimulus: the
//   default 16-bit counter build and a 2-bit counter build that reaches
//   saturation quickly. Inputs are driven on the falling edge; transfers are
//   decided and outputs sampled 1 time unit later, away from the rising edge.

module tb_squid_error_corrector;

  localparam logic [1:0] ST_NE  = 2'b00;
  localparam logic [1:0] ST_CE  = 2'b01;
  localparam logic [1:0] ST_DUE = 2'b10;
  localparam int         W      = 37;  // {codeword, status, err_sym}

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid;
  logic        in_ready, sat_in_ready;
  logic [31:0] in_codeword;
  logic [3:0]  in_magnitude [7:0];
  logic [7:0]  in_err_loc;
  logic        in_synd_zero;
  logic        out_valid, sat_out_valid;
  logic        out_ready;
  logic [31:0] out_codeword, sat_out_codeword;
  logic [1:0]  out_status, sat_out_status;
  logic [2:0]  out_err_sym, sat_out_err_sym;
  logic [15:0] ce_count, due_count;
  logic [1:0]  sat_ce_count, sat_due_count;
  logic        cnt_clear;

  squid_error_corrector dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_codeword(in_codeword), .in_magnitude(in_magnitude),
    .in_err_loc(in_err_loc), .in_synd_zero(in_synd_zero),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_codeword(out_codeword), .out_status(out_status),
    .out_err_sym(out_err_sym),
    .ce_count(ce_count), .due_count(due_count), .cnt_clear(cnt_clear)
  );

  squid_error_corrector #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(sat_in_ready),
    .in_codeword(in_codeword), .in_magnitude(in_magnitude),
    .in_err_loc(in_err_loc), .in_synd_zero(in_synd_zero),
    .out_valid(sat_out_valid), .out_ready(out_ready),
    .out_codeword(sat_out_codeword), .out_status(sat_out_status),
    .out_err_sym(sat_out_err_sym),
    .ce_count(sat_ce_count), .due_count(sat_due_count), .cnt_clear(cnt_clear)
  );

  // ---------------------------------------------------------------- scoreboard
  logic [W-1:0] exp_q[$];
  int unsigned  ce_m, due_m, ce_s, due_s;   // model counters (16-bit / 2-bit)
  int           n_tests = 0;
  int           n_fail  = 0;
  logic         hold_pending = 1'b0;
  logic [W-1:0] held;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decoder, from the classification rules directly.
  function automatic logic [W-1:0] ref_model(input logic [31:0] cw,
      input logic [31:0] mag, input logic [7:0] loc, input logic sz);
    int k;
    logic [3:0] m;
    if (sz) return {cw, ST_NE, 3'd0};
    if ($countones(loc) != 1) return {cw, ST_DUE, 3'd0};
    k = 0;
    for (int i = 0; i < 8; i++) if (loc[i]) k = i;
    m = mag[4*k +: 4];
    if (m == 4'h0) return {cw, ST_DUE, 3'd0};
    return {cw ^ (32'(m) << (4*k)), ST_CE, 3'(k)};
  endfunction

  // ---------------------------------------------------------------- driver
  // Called right after a falling edge; returns at the next falling edge.
  task automatic cycle(input logic v, input logic [31:0] cw,
      input logic [31:0] mag, input logic [7:0] loc, input logic sz,
      input logic ordy, input logic clr, input logic [W-1:0] exp,
      output logic acc);
    logic [W-1:0] want;
    logic ce_inc, due_inc;
    in_valid = v; in_codeword = cw; in_err_loc = loc; in_synd_zero = sz;
    for (int i = 0; i < 8; i++) in_magnitude[i] = mag[4*i +: 4];
    out_ready = ordy; cnt_clear = clr;
    #1;
    check("ce_count", 64'(ce_count), 64'(ce_m));
    check("due_count", 64'(due_count), 64'(due_m));
    check("sat_ce_count", 64'(sat_ce_count), 64'(ce_s));
    check("sat_due_count", 64'(sat_due_count), 64'(due_s));
    // Two beats in flight means both stages are full.
    check("in_ready", 64'(in_ready), 64'(!(exp_q.size() >= 2 && !ordy)));
    check("sat_in_ready", 64'(sat_in_ready), 64'(!(exp_q.size() >= 2 && !ordy)));
    if (hold_pending && out_valid)
      check("stall_hold", 64'({out_codeword, out_status, out_err_sym}), 64'(held));
    hold_pending = out_valid && !ordy;
    held = {out_codeword, out_status, out_err_sym};
    acc = v && in_ready;
    ce_inc = 1'b0; due_inc = 1'b0;
    if (out_valid && ordy) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL extra_out: got beat %0h expected none",
                 {out_codeword, out_status, out_err_sym});
      end else begin
        want = exp_q.pop_front();
        check("out_beat", 64'({out_codeword, out_status, out_err_sym}), 64'(want));
        check("sat_out_beat", 64'({sat_out_codeword, sat_out_status, sat_out_err_sym}),
              64'(want));
        ce_inc  = (want[4:3] == ST_CE);
        due_inc = (want[4:3] == ST_DUE);
      end
    end
    if (acc) exp_q.push_back(exp);
    if (clr) begin
      ce_m = 0; due_m = 0; ce_s = 0; due_s = 0;
    end else begin
      if (ce_inc) begin
        if (ce_m < 65535) ce_m++;
        if (ce_s < 3) ce_s++;
      end
      if (due_inc) begin
        if (due_m < 65535) due_m++;
        if (due_s < 3) due_s++;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle(input logic ordy, input logic clr);
    logic acc;
    cycle(1'b0, $urandom, $urandom, 8'($urandom), 1'b0, ordy, clr, '0, acc);
  endtask

  task automatic send(input logic [31:0] cw, input logic [31:0] mag,
      input logic [7:0] loc, input logic sz, input logic [W-1:0] exp);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 10 && !acc; t++) cycle(1'b1, cw, mag, loc, sz, 1'b1, 1'b0, exp, acc);
    check("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic drain();
    for (int t = 0; t < 10 && exp_q.size() != 0; t++) idle(1'b1, 1'b0);
    check("drain_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic rand_vec(output logic [31:0] cw, output logic [31:0] mag,
      output logic [7:0] loc, output logic sz);
    int kind, a, b;
    cw = $urandom; mag = $urandom; sz = 1'b0;
    kind = $urandom_range(0, 9);
    a = $urandom_range(0, 7);
    b = (a + $urandom_range(1, 7)) % 8;
    case (kind)
      0, 1:          begin sz = 1'b1; loc = 8'($urandom); end
      2, 3, 4, 5, 6: loc = 8'(1) << a;
      7:             loc = 8'h00;
      8:             loc = (8'(1) << a) | (8'(1) << b);
      default:       begin loc = 8'(1) << a; mag[4*a +: 4] = 4'h0; end
    endcase
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic [31:0] cw;
    logic [31:0] mag;
    logic [7:0]  loc;
    logic        sz;
    logic [31:0] exp_cw;
    logic [1:0]  exp_st;
    logic [2:0]  exp_sym;
  } vec_t;

  vec_t vecs [8];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        acc, saw_stall;
    logic [31:0] cw, mag;
    logic [7:0]  loc;
    logic        sz, v, ordy;
    int          sent;

    vecs[0] = '{32'h1234_5678, 32'h0000_0000, 8'h00, 1'b1, 32'h1234_5678, ST_NE,  3'd0};
    vecs[1] = '{32'h1234_5678, 32'h0000_0A00, 8'h04, 1'b0, 32'h1234_5C78, ST_CE,  3'd2};
    vecs[2] = '{32'h1234_5678, 32'h1111_1111, 8'h12, 1'b0, 32'h1234_5678, ST_DUE, 3'd0};
    vecs[3] = '{32'h1234_5678, 32'h1111_1111, 8'h00, 1'b0, 32'h1234_5678, ST_DUE, 3'd0};
    vecs[4] = '{32'h1234_5678, 32'hFFFF_FFF0, 8'h01, 1'b0, 32'h1234_5678, ST_DUE, 3'd0};
    vecs[5] = '{32'hFFFF_FFFF, 32'hF000_0000, 8'h80, 1'b0, 32'h0FFF_FFFF, ST_CE,  3'd7};
    vecs[6] = '{32'hDEAD_BEEF, 32'h0000_0A00, 8'h04, 1'b1, 32'hDEAD_BEEF, ST_NE,  3'd0};
    vecs[7] = '{32'h0000_0000, 32'h9999_9993, 8'h01, 1'b0, 32'h0000_0003, ST_CE,  3'd0};

    // ---- reset state
    rst = 1'b1; in_valid = 1'b0; in_codeword = '0; in_err_loc = '0;
    in_synd_zero = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
    for (int i = 0; i < 8; i++) in_magnitude[i] = '0;
    ce_m = 0; due_m = 0; ce_s = 0; due_s = 0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_codeword", 64'(out_codeword), 64'd0);
    check("rst_out_status", 64'(out_status), 64'd0);
    check("rst_out_err_sym", 64'(out_err_sym), 64'd0);
    check("rst_counters", 64'({ce_count, due_count}), 64'd0);
    rst = 1'b0;

    // ---- latency: accepted in cycle N, out_valid in cycle N+2
    cycle(1'b1, vecs[0].cw, vecs[0].mag, vecs[0].loc, vecs[0].sz, 1'b0, 1'b0,
          {vecs[0].exp_cw, vecs[0].exp_st, vecs[0].exp_sym}, acc);
    check("lat_accept", 64'(acc), 64'd1);
    check("lat_n1_out_valid", 64'(out_valid), 64'd0);
    idle(1'b0, 1'b0);
    check("lat_n2_out_valid", 64'(out_valid), 64'd1);
    drain();

    // ---- directed table, full throughput
    foreach (vecs[i])
      send(vecs[i].cw, vecs[i].mag, vecs[i].loc, vecs[i].sz,
           {vecs[i].exp_cw, vecs[i].exp_st, vecs[i].exp_sym});
    drain();
    check("table_ce_count", 64'(ce_count), 64'd3);
    check("table_due_count", 64'(due_count), 64'd3);

    // ---- 6 beats back-to-back, out_ready low in cycles 3..5
    saw_stall = 1'b0; sent = 0;
    for (int i = 0; i < 16; i++) begin
      v = (sent < 6);
      cw = 32'hA0A0_0000 + 32'(sent);
      mag = 32'h0000_0050; loc = 8'h02; sz = 1'b0;
      cycle(v, cw, mag, loc, sz, !(i >= 3 && i <= 5), 1'b0,
            ref_model(cw, mag, loc, sz), acc);
      if (v && !acc) saw_stall = 1'b1;
      if (acc) sent++;
    end
    check("stream_in_ready_fell", 64'(saw_stall), 64'd1);
    check("stream_sent", 64'(sent), 64'd6);
    drain();

    // ---- randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      rand_vec(cw, mag, loc, sz);
      cycle($urandom_range(0, 3) != 0, cw, mag, loc, sz,
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0,
            ref_model(cw, mag, loc, sz), acc);
    end
    drain();

    // ---- saturation of the 2-bit build, then clear racing an increment
    idle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) send(32'h1234_5678, 32'h0000_0A00, 8'h04, 1'b0,
                                     {32'h1234_5C78, ST_CE, 3'd2});
    drain();
    check("sat_ce_holds", 64'(sat_ce_count), 64'd3);
    check("wide_ce_count", 64'(ce_count), 64'd5);
    send(32'h1234_5678, 32'h0000_0A00, 8'h04, 1'b0, {32'h1234_5C78, ST_CE, 3'd2});
    check("clr_race_pending", 64'(out_valid), 64'd0);
    check("clr_race_ready", 64'(exp_q.size()), 64'd1);
    idle(1'b1, 1'b0);                 // beat now in the output stage
    check("clr_race_valid", 64'(out_valid), 64'd1);
    idle(1'b1, 1'b1);                 // out transfer and clear together
    check("clr_race_ce", 64'(ce_count), 64'd0);
    check("clr_race_sat_ce", 64'(sat_ce_count), 64'd0);

    // ---- asynchronous reset with both stages full
    send(32'h0000_0001, 32'h0000_0001, 8'h01, 1'b0, {32'h0000_0000, ST_CE, 3'd0});
    drain();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 32'h5555_0000 + 32'(i), 32'h0000_0001, 8'h01, 1'b0, 1'b0, 1'b0,
            ref_model(32'h5555_0000 + 32'(i), 32'h0000_0001, 8'h01, 1'b0), acc);
    end
    check("full_in_ready", 64'(in_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_sat_out_valid", 64'(sat_out_valid), 64'd0);
    check("arst_counters", 64'({ce_count, due_count}), 64'd0);
    check("arst_sat_counters", 64'({sat_ce_count, sat_due_count}), 64'd0);
    exp_q.delete();
    ce_m = 0; due_m = 0; ce_s = 0; due_s = 0;
    hold_pending = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 32'h8765_4321, 32'h0000_0000, 8'h00, 1'b1, 1'b1, 1'b0,
          {32'h8765_4321, ST_NE, 3'd0}, acc);
    check("post_rst_accept", 64'(acc), 64'd1);
    check("post_rst_n1_valid", 64'(out_valid), 64'd0);
    idle(1'b0, 1'b0);
    check("post_rst_n2_valid", 64'(out_valid), 64'd1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
